// File: rtl/rv_mem_pkg.sv
// Shared constants and types for the memory / MMIO subsystem.
package rv_mem_pkg;

  localparam logic [31:0] MMIO_BASE       = 32'h8000_0000;
  localparam logic [7:0]  OFF_LED         = 8'h00;
  localparam logic [7:0]  OFF_CYCLE       = 8'h04;
  localparam logic [7:0]  OFF_UART_TX     = 8'h08;
  localparam logic [7:0]  OFF_UART_STATUS = 8'h0C;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A frame is start(0), 8 data bits LSB first, stop(1).
// 'accept' reports that 'start' was taken this cycle, which includes the last
// cycle of a stop bit so that frames can be sent back to back.
module uart_tx
  import rv_mem_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       accept
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  uart_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            bit_done;

  // End of the current bit period and start acceptance.
  always_comb begin
    bit_done = (cnt_q == CntLast);
    accept   = start && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
  end

  // Frame sequencer with registered line output; reset forces the line idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else if (accept) begin
      state_q <= START;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= data;
      tx_q    <= 1'b0;
    end else begin
      if (state_q != IDLE) begin
        cnt_q <= bit_done ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: rtl/rv_mem_subsystem.sv
// Unified instruction/data RAM plus MMIO (LED, cycle counter, optional UART)
// for the multicycle RISC-V core. Reads are registered (1-cycle latency).
// Define RV_MMIO_UART_EN to build the UART_TX/UART_STATUS registers and
// the transmitter; otherwise uart_tx is tied high.
module rv_mem_subsystem
  import rv_mem_pkg::*;
#(
  parameter int unsigned DEPTH        = 1024,
  parameter string       INIT_FILE    = "",
  parameter int unsigned LED_W        = 8,
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Adr,
  input  logic             MemWrite,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic [LED_W-1:0] leds,
  output logic             uart_tx
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] RamBytes = 32'(DEPTH * 4);

  logic [31:0]      ram_q [DEPTH];
  logic [AW-1:0]    ram_idx;
  logic             is_ram;
  logic             is_mmio;
  logic [7:0]       mmio_off;
  logic [31:0]      mmio_rdata;
  logic [31:0]      read_data_d, read_data_q;
  logic [LED_W-1:0] led_d, led_q;
  logic [31:0]      cycle_d, cycle_q;

  // Address decode; Adr[1:0] is ignored by construction.
  always_comb begin
    ram_idx  = Adr[AW+1:2];
    is_ram   = (Adr < RamBytes);
    is_mmio  = (Adr[31:8] == MMIO_BASE[31:8]);
    mmio_off = Adr[7:0];
  end

`ifdef RV_MMIO_UART_EN
  logic       uart_start;
  logic       uart_busy;
  logic       uart_accept;
  logic [7:0] uart_byte_d, uart_byte_q;

  // Write strobe to UART_TX and capture of the last accepted byte.
  always_comb begin
    uart_start  = MemWrite && is_mmio && (mmio_off == OFF_UART_TX);
    uart_byte_d = uart_accept ? WriteData[7:0] : uart_byte_q;
  end

  // Last accepted byte register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uart_byte_q <= '0;
    end else begin
      uart_byte_q <= uart_byte_d;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .reset (reset),
    .start (uart_start),
    .data  (WriteData[7:0]),
    .tx    (uart_tx),
    .busy  (uart_busy),
    .accept(uart_accept)
  );
`else
  assign uart_tx = 1'b1;
`endif

  // MMIO read mux, LED/cycle next state and the registered read data.
  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      OFF_LED:         mmio_rdata = 32'(led_q);
      OFF_CYCLE:       mmio_rdata = cycle_q;
`ifdef RV_MMIO_UART_EN
      OFF_UART_TX:     mmio_rdata = {24'h0, uart_byte_q};
      OFF_UART_STATUS: mmio_rdata = {31'h0, uart_busy};
`endif
      default:         mmio_rdata = '0;
    endcase

    if (is_ram) begin
      read_data_d = ram_q[ram_idx];
    end else if (is_mmio) begin
      read_data_d = mmio_rdata;
    end else begin
      read_data_d = '0;
    end

    led_d = led_q;
    if (MemWrite && is_mmio && (mmio_off == OFF_LED)) begin
      led_d = WriteData[LED_W-1:0];
    end

    cycle_d = cycle_q + 32'd1;
  end

  // Resettable MMIO state and read data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_q <= '0;
      led_q       <= '0;
      cycle_q     <= '0;
    end else begin
      read_data_q <= read_data_d;
      led_q       <= led_d;
      cycle_q     <= cycle_d;
    end
  end

  // RAM write port; not reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (MemWrite && is_ram) begin
      ram_q[ram_idx] <= WriteData;
    end
  end

  assign ReadData = read_data_q;
  assign leds     = led_q;

endmodule

// File: tb/tb_rv_mem_subsystem.sv
// Scoreboard bench for rv_mem_subsystem. Reads push their expected data; a
// monitor pops and compares when the registered ReadData appears.
module tb_rv_mem_subsystem;

  localparam int unsigned CPB = 4;
  localparam logic [31:0] A_LED    = 32'h8000_0000;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0004;
  localparam logic [31:0] A_TX     = 32'h8000_0008;
  localparam logic [31:0] A_STATUS = 32'h8000_000C;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] Adr;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  leds;
  logic        uart_tx;

  logic        rd_req;
  logic        rd_pend;
  logic [31:0] tb_cyc;
  exp_t        sb_q[$];
  int          checks;
  int          failures;

  rv_mem_subsystem #(
    .DEPTH       (1024),
    .INIT_FILE   (""),
    .LED_W       (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Adr      (Adr),
    .MemWrite (MemWrite),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .leds     (leds),
    .uart_tx  (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A read issued before an edge is answered after that edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) rd_pend <= 1'b0;
    else        rd_pend <= rd_req;
  end

  // Reference cycle count: edges since reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  // Monitor: compare ReadData against the oldest expectation.
  always @(negedge clk) begin
    if (rd_pend) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow actual=%h required=<no entry>", ReadData);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (ReadData !== e.exp) begin
          failures++;
          $display("FAIL %s actual=%h required=%h", e.name, ReadData, e.exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input string n, input logic [31:0] e);
    exp_t x;
    x.name = n;
    x.exp  = e;
    sb_q.push_back(x);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    Adr = a; MemWrite = 1'b0; rd_req = 1'b1;
    push(n, e);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Adr = a; WriteData = d; MemWrite = 1'b1; rd_req = 1'b0;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  // Write and read the same address in one cycle; expect the old value.
  task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e,
                    input string n);
    Adr = a; WriteData = d; MemWrite = 1'b1; rd_req = 1'b1;
    push(n, e);
    @(negedge clk);
    MemWrite = 1'b0; rd_req = 1'b0;
  endtask

`ifdef RV_MMIO_UART_EN
  // Checks one frame of byte b starting the cycle after its accepting edge.
  task automatic frame(input logic [7:0] b, input int ncyc, input bit chain,
                       input logic [7:0] nb);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < ncyc; k++) begin
      chk($sformatf("tx_%02h_k%0d", b, k), {31'h0, uart_tx}, {31'h0, fr[k/CPB]});
      MemWrite = 1'b0; rd_req = 1'b0; Adr = 32'h8000_0010;
      if (k == 5 || k == 38) begin
        Adr = A_STATUS; rd_req = 1'b1; push($sformatf("busy_k%0d", k), 32'd1);
      end else if (k == 10) begin
        Adr = A_TX; WriteData = 32'hFF; MemWrite = 1'b1;
      end else if (k == 12) begin
        Adr = A_TX; rd_req = 1'b1; push("last_byte_mid", {24'h0, b});
      end else if (k == 39) begin
        if (chain) begin
          Adr = A_TX; WriteData = {24'h0, nb}; MemWrite = 1'b1; rd_req = 1'b1;
          push("b2b_old_byte", {24'h0, b});
        end else begin
          Adr = A_STATUS; rd_req = 1'b1; push("busy_last", 32'd1);
        end
      end
      @(negedge clk);
    end
    MemWrite = 1'b0; rd_req = 1'b0;
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; Adr = '0; MemWrite = 1'b0; WriteData = '0; rd_req = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_leds", {24'h0, leds}, 32'h0);
    chk("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    reset = 1'b1;

    // Nine edges elapse, the read is captured at the tenth: count before it is 9.
    repeat (9) @(negedge clk);
    rd(A_CYCLE, 32'd9, "cycle_after_release");

    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
    rw(32'h10, 32'h1234_5678, 32'hDEAD_BEEF, "ram_rdw_old");
    rd(32'h10, 32'h1234_5678, "ram_rd_new");
    rd(32'h13, 32'h1234_5678, "ram_byte_offset_ignored");

    wr(A_LED, 32'hA5);
    chk("leds_a5", {24'h0, leds}, 32'hA5);
    rd(A_LED, 32'hA5, "led_rd");
    wr(A_LED, 32'hFFFF_FF3C);
    chk("leds_trunc", {24'h0, leds}, 32'h3C);
    rd(A_LED, 32'h3C, "led_rd_zext");

    // RAM bounds and unmapped space; the dropped writes would alias word 0.
    wr(32'h0, 32'h1111_1111);
    wr(32'hFFC, 32'h2222_2222);
    wr(32'h1000, 32'h9999_9999);
    wr(32'h0001_0000, 32'h7777_7777);
    rd(32'h0001_0000, 32'h0, "unmapped_rd");
    rd(32'h1000, 32'h0, "past_ram_rd");
    rd(32'h0, 32'h1111_1111, "word0_intact");
    rd(32'hFFC, 32'h2222_2222, "last_word");
    rd(32'h10, 32'h1234_5678, "word4_intact");
    rd(32'h8000_0010, 32'h0, "mmio_bad_off");
    rd(32'h8000_0100, 32'h0, "mmio_outside");

    wr(A_CYCLE, 32'h0);
    rd(A_CYCLE, tb_cyc, "cycle_write_ignored");

`ifdef RV_MMIO_UART_EN
    rd(A_STATUS, 32'h0, "status_idle");
    rw(A_TX, 32'h55, 32'h0, "tx_rd_before_accept");
    frame(8'h55, 40, 1'b0, 8'h00);
    chk("tx_idle_after", {31'h0, uart_tx}, 32'h1);
    rd(A_STATUS, 32'h0, "busy_cleared");
    rd(A_TX, 32'h55, "last_byte_55");

    rw(A_TX, 32'hA3, 32'h55, "tx_rd_a3_old");
    frame(8'hA3, 40, 1'b1, 8'h0F);
    frame(8'h0F, 21, 1'b0, 8'h00);
    chk("tx_in_data", {31'h0, uart_tx}, 32'h0);
    reset = 1'b0;
    #1;
    chk("tx_async_reset", {31'h0, uart_tx}, 32'h1);
    chk("leds_mid_reset", {24'h0, leds}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rd(A_STATUS, 32'h0, "busy_after_reset");
    rd(A_TX, 32'h0, "last_byte_reset");
`else
    rw(A_TX, 32'h41, 32'h0, "tx_rd_disabled");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("tx_stays_idle_k%0d", k), {31'h0, uart_tx}, 32'h1);
      @(negedge clk);
    end
    rd(A_TX, 32'h0, "tx_reg_disabled");
    rd(A_STATUS, 32'h0, "status_disabled");
    reset = 1'b0;
    #1;
    chk("leds_mid_reset", {24'h0, leds}, 32'h0);
    chk("readdata_mid_reset", ReadData, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
`endif

    rd(32'h10, 32'h1234_5678, "ram_after_reset");
    rd(32'hFFC, 32'h2222_2222, "ram_last_after_reset");
    rd(A_LED, 32'h0, "led_after_reset");
    repeat (3) @(negedge clk);
    rd(A_CYCLE, tb_cyc, "cycle_after_reset");
    repeat (2) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
